// File: rtl/bus_pkg.sv
// bus_pkg
//   Shared definitions for the slave side of the serial 1-bit system bus:
//   bus address split, default handshake length and the slave port state type.
package bus_pkg;

  localparam int BUS_ADDR_W      = 16;  // full serial bus address
  localparam int SEL_W           = 4;   // upper bits consumed by the address decoder
  localparam int SLV_ADDR_W      = BUS_ADDR_W - SEL_W;
  localparam int ACK_CYCLES_DFLT = 2;   // B_ACK pulse length in clock cycles

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_RW,
    ST_ACKA,
    ST_WDATA,
    ST_WCMT,
    ST_ACKW,
    ST_RREQ,
    ST_RWAIT,
    ST_ACKR,
    ST_RDATA
  } bus_slv_state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic is_ack_state(input bus_slv_state_t s);
    return (s == ST_ACKA) || (s == ST_ACKW) || (s == ST_ACKR);
  endfunction

endpackage

// File: rtl/serial_shift_reg.sv
// serial_shift_reg
//   MSB-first shift register with parallel load and a saturating bit counter.
//   Shifting moves every bit one place towards the MSB and inserts sin at the
//   LSB, so the same operation deserialises (sin = line) and serialises
//   (the caller reads value[W-1] before each shift).
// Ports
//   clk, rst_n  clock, asynchronous active-low reset
//   clr         zero the bit counter (may coincide with shift: counter -> 1)
//   load        parallel load of load_val, counter -> 0 (wins over shift)
//   shift, sin  shift one bit in at the LSB
//   value       register contents
//   count       bits shifted since last clr/load, saturates at W
//   done        count has reached W
module serial_shift_reg #(
  parameter int W     = 8,
  parameter int CNT_W = $clog2(W + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             load,
  input  logic [W-1:0]     load_val,
  input  logic             shift,
  input  logic             sin,
  output logic [W-1:0]     value,
  output logic [CNT_W-1:0] count,
  output logic             done
);

  localparam logic [CNT_W-1:0] TERM = CNT_W'(W);

  logic [W-1:0]     value_reg;
  logic [CNT_W-1:0] count_reg;
  logic [CNT_W-1:0] cnt_base;

  // Counter origin for this edge: a clear/load restarts from zero.
  always_comb cnt_base = (clr || load) ? '0 : count_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_reg <= '0;
      count_reg <= '0;
    end else begin
      if (load)
        value_reg <= load_val;
      else if (shift)
        value_reg <= {value_reg[W-2:0], sin};

      if (shift && !load && (cnt_base != TERM))
        count_reg <= cnt_base + 1'b1;
      else
        count_reg <= cnt_base;
    end
  end

  assign value = value_reg;
  assign count = count_reg;
  assign done  = (count_reg == TERM);

endmodule

// File: rtl/bus_slave_port.sv
// bus_slave_port
//   Slave endpoint of the serial 1-bit system bus. Deserialises address, RW
//   and write data from B_BUS_IN, handshakes with B_ACK, issues single-cycle
//   strobes to local memory and serialises read data back on B_BUS_OUT.
// Ports
//   CLK, RSTN           clock, asynchronous active-low reset
//   B_UTIL, S_SEL       frame active / decoder select; act = B_UTIL & S_SEL
//   B_BUS_IN            serial master->slave line, MSB first
//   B_BUS_OUT, B_ACK    serial read data / handshake (registered)
//   S_ADDR, S_WDATA     captured address / write data (hold until overwritten)
//   S_WE, S_RE          one-cycle memory strobes (registered)
//   S_READY             memory accepts a strobe
//   S_RDATA, S_RVALID   read return from memory
module bus_slave_port
  import bus_pkg::*;
#(
  parameter int ADDR_W     = SLV_ADDR_W,
  parameter int DATA_W     = 8,
  parameter int ACK_CYCLES = ACK_CYCLES_DFLT
) (
  input  logic              CLK,
  input  logic              RSTN,
  input  logic              B_UTIL,
  input  logic              S_SEL,
  input  logic              B_BUS_IN,
  output logic              B_BUS_OUT,
  output logic              B_ACK,
  output logic [ADDR_W-1:0] S_ADDR,
  output logic [DATA_W-1:0] S_WDATA,
  output logic              S_WE,
  output logic              S_RE,
  input  logic              S_READY,
  input  logic [DATA_W-1:0] S_RDATA,
  input  logic              S_RVALID
);

  localparam int CNT_W = $clog2(max_int(ADDR_W, DATA_W) + 1);
  localparam int ACK_W = $clog2(ACK_CYCLES + 1);
  localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_W - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
  localparam logic [ACK_W-1:0] ACK_LAST  = ACK_W'(ACK_CYCLES - 1);

  bus_slv_state_t state_reg, state_next;
  logic             act;
  logic             armed_reg;
  logic [ACK_W-1:0] ack_cnt_reg;
  logic             ack_last;
  logic             b_ack_reg, b_ack_next;
  logic             s_we_reg, s_we_next;
  logic             s_re_reg, s_re_next;
  logic             b_bus_out_reg, b_bus_out_next;
  logic [ADDR_W-1:0] s_addr_reg;
  logic [DATA_W-1:0] s_wdata_reg;

  logic              addr_clr, addr_shift, addr_done;
  logic [ADDR_W-1:0] addr_val;
  logic [CNT_W-1:0]  addr_cnt;
  logic              data_clr, data_load, data_shift, data_sin, data_done;
  logic [DATA_W-1:0] data_val;
  logic [CNT_W-1:0]  data_cnt;

  assign act      = B_UTIL & S_SEL;
  assign ack_last = (ack_cnt_reg == ACK_LAST);

  serial_shift_reg #(.W(ADDR_W), .CNT_W(CNT_W)) u_addr_sr (
    .clk(CLK), .rst_n(RSTN), .clr(addr_clr), .load(1'b0), .load_val('0),
    .shift(addr_shift), .sin(B_BUS_IN),
    .value(addr_val), .count(addr_cnt), .done(addr_done)
  );

  // Shared data register: write data shifts in during WDATA, read data is
  // loaded on S_RVALID and shifted out during RDATA.
  serial_shift_reg #(.W(DATA_W), .CNT_W(CNT_W)) u_data_sr (
    .clk(CLK), .rst_n(RSTN), .clr(data_clr), .load(data_load), .load_val(S_RDATA),
    .shift(data_shift), .sin(data_sin),
    .value(data_val), .count(data_cnt), .done(data_done)
  );

  // State register plus the registered outputs.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_reg     <= ST_IDLE;
      armed_reg     <= 1'b0;
      ack_cnt_reg   <= '0;
      b_ack_reg     <= 1'b0;
      s_we_reg      <= 1'b0;
      s_re_reg      <= 1'b0;
      b_bus_out_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      // A new frame is accepted only after act has been seen low.
      armed_reg     <= !act || (armed_reg && (state_reg != ST_IDLE));
      ack_cnt_reg   <= (is_ack_state(state_reg) && (state_next == state_reg))
                       ? ack_cnt_reg + 1'b1 : '0;
      b_ack_reg     <= b_ack_next;
      s_we_reg      <= s_we_next;
      s_re_reg      <= s_re_next;
      b_bus_out_reg <= b_bus_out_next;
    end
  end

  // Next-state logic. Dropping act aborts any frame in progress.
  always_comb begin
    state_next = state_reg;
    if (state_reg == ST_IDLE) begin
      if (act && armed_reg) state_next = ST_ADDR;
    end else if (!act) begin
      state_next = ST_IDLE;
    end else begin
      case (state_reg)
        ST_ADDR:  if (addr_cnt == ADDR_LAST) state_next = ST_RW;
        ST_RW:    state_next = B_BUS_IN ? ST_ACKA : ST_RREQ;
        ST_ACKA:  if (ack_last) state_next = ST_WDATA;
        ST_WDATA: if (data_cnt == DATA_LAST) state_next = ST_WCMT;
        ST_WCMT:  if (s_we_reg) state_next = ST_ACKW;  // strobe just issued
        ST_ACKW:  if (ack_last) state_next = ST_IDLE;
        ST_RREQ:  if (S_READY) state_next = ST_RWAIT;
        ST_RWAIT: if (S_RVALID) state_next = ST_ACKR;
        ST_ACKR:  if (ack_last) state_next = ST_RDATA;
        ST_RDATA: if (data_done) state_next = ST_IDLE;
        default:  state_next = ST_IDLE;
      endcase
    end
  end

  // Output / datapath control logic.
  always_comb begin
    b_ack_next     = is_ack_state(state_next);
    s_we_next      = act && (state_reg == ST_WCMT) && !s_we_reg && S_READY;
    s_re_next      = act && (state_reg == ST_RREQ) && S_READY;
    // Each RDATA cycle shows the current MSB; the register shifts on the same edge.
    b_bus_out_next = (state_next == ST_RDATA) ? data_val[DATA_W-1] : 1'b0;

    addr_clr   = (state_reg == ST_IDLE);
    addr_shift = ((state_reg == ST_IDLE) && (state_next == ST_ADDR)) ||
                 ((state_reg == ST_ADDR) && act);
    data_clr   = (state_reg == ST_ACKA);
    data_load  = (state_reg == ST_RWAIT) && (state_next == ST_ACKR);
    data_shift = ((state_reg == ST_WDATA) && act) || (state_next == ST_RDATA);
    data_sin   = (state_reg == ST_WDATA) && B_BUS_IN;
  end

  // Published address / write data; only a complete capture is exposed.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      s_addr_reg  <= '0;
      s_wdata_reg <= '0;
    end else begin
      if ((state_reg == ST_RW) && act && addr_done) s_addr_reg <= addr_val;
      if ((state_reg == ST_WCMT) && act)            s_wdata_reg <= data_val;
    end
  end

  assign B_ACK     = b_ack_reg;
  assign S_WE      = s_we_reg;
  assign S_RE      = s_re_reg;
  assign B_BUS_OUT = b_bus_out_reg;
  assign S_ADDR    = s_addr_reg;
  assign S_WDATA   = s_wdata_reg;

endmodule

// File: tb/tb_bus_slave_port.sv
// tb_bus_slave_port
//   Bench acting as bus master and as the local memory. A memory array is the
//   reference: writes must strobe the framed address/data, reads must return
//   the array contents serially after the handshake.
module tb_bus_slave_port;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 8;
  localparam int ACKC   = 2;

  logic              CLK = 1'b0;
  logic              RSTN = 1'b1;
  logic              B_UTIL = 1'b0;
  logic              S_SEL = 1'b0;
  logic              B_BUS_IN = 1'b0;
  logic              S_READY = 1'b0;
  logic              S_RVALID = 1'b0;
  logic [DATA_W-1:0] S_RDATA = '0;
  logic              B_BUS_OUT, B_ACK, S_WE, S_RE;
  logic [ADDR_W-1:0] S_ADDR;
  logic [DATA_W-1:0] S_WDATA;

  always #5 CLK = ~CLK;

  bus_slave_port #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ACK_CYCLES(ACKC)) dut (
    .CLK(CLK), .RSTN(RSTN), .B_UTIL(B_UTIL), .S_SEL(S_SEL), .B_BUS_IN(B_BUS_IN),
    .B_BUS_OUT(B_BUS_OUT), .B_ACK(B_ACK), .S_ADDR(S_ADDR), .S_WDATA(S_WDATA),
    .S_WE(S_WE), .S_RE(S_RE), .S_READY(S_READY), .S_RDATA(S_RDATA), .S_RVALID(S_RVALID)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int we_seen = 0, re_seen = 0, ack_seen = 0, out_seen = 0;
  logic [DATA_W-1:0] mem [4096];
  logic [DATA_W-1:0] last_wdata = '0;
  logic [ADDR_W-1:0] wq[$];

  // Activity counters sampled mid-cycle.
  always @(negedge CLK) begin
    we_seen  <= we_seen  + int'(S_WE);
    re_seen  <= re_seen  + int'(S_RE);
    ack_seen <= ack_seen + int'(B_ACK);
    out_seen <= out_seen + int'(B_BUS_OUT);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic send_addr(input logic [ADDR_W-1:0] a);
    B_UTIL = 1'b1;
    S_SEL  = 1'b1;
    for (int i = ADDR_W - 1; i >= 0; i--) begin
      B_BUS_IN = a[i];
      step();
    end
  endtask

  task automatic wait_ack(input string tag);
    int w = 0;
    while (B_ACK === 1'b1 && w < 20) begin
      w++;
      step();
    end
    check(tag, w, ACKC);
  endtask

  task automatic idle_watch(input string tag, input int n);
    int w0, r0, a0, o0;
    w0 = we_seen; r0 = re_seen; a0 = ack_seen; o0 = out_seen;
    for (int i = 0; i < n; i++) begin
      B_BUS_IN = 1'($urandom);
      S_READY  = 1'($urandom);
      S_RVALID = 1'($urandom);
      step();
    end
    B_BUS_IN = 1'b0; S_READY = 1'b0; S_RVALID = 1'b0;
    check({tag, "_we"},  we_seen - w0,  0);
    check({tag, "_re"},  re_seen - r0,  0);
    check({tag, "_ack"}, ack_seen - a0, 0);
    check({tag, "_out"}, out_seen - o0, 0);
  endtask

  task automatic write_frame(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                             input int k, input bit hold);
    int lat = 0;
    send_addr(a);
    B_BUS_IN = 1'b1;
    check("wr_ack_before_rw", B_ACK, 0);
    step();
    check("wr_acka_start", B_ACK, 1);
    wait_ack("wr_acka_len");
    for (int i = DATA_W - 1; i >= 0; i--) begin
      B_BUS_IN = d[i];
      step();
    end
    B_BUS_IN = 1'b0;
    while (S_WE !== 1'b1 && lat < 64) begin
      S_READY = (lat >= k);
      step();
      lat++;
    end
    S_READY = 1'b0;
    check("wr_we_latency", lat, k + 1);
    check("wr_addr", S_ADDR, a);
    check("wr_data", S_WDATA, d);
    check("wr_ack_during_we", B_ACK, 0);
    step();
    check("wr_we_single", S_WE, 0);
    check("wr_ackw_start", B_ACK, 1);
    wait_ack("wr_ackw_len");
    mem[a] = d;
    last_wdata = d;
    wq.push_back(a);
    $display("write addr=%03h data=%02h ready_delay=%0d", a, d, k);
    if (!hold) begin
      B_UTIL = 1'b0; S_SEL = 1'b0;
      step();
    end
  endtask

  task automatic read_frame(input logic [ADDR_W-1:0] a, input int k, input int rl,
                            input int rst_bit);
    int lat = 0;
    logic [DATA_W-1:0] bits = '0;
    send_addr(a);
    B_BUS_IN = 1'b0;
    step();
    check("rd_no_ack_rreq", B_ACK, 0);
    while (S_RE !== 1'b1 && lat < 64) begin
      S_READY = (lat >= k);
      step();
      lat++;
    end
    S_READY = 1'b0;
    check("rd_re_latency", lat, k + 1);
    check("rd_addr", S_ADDR, a);
    repeat (rl) step();
    check("rd_no_ack_rwait", B_ACK, 0);
    S_RVALID = 1'b1;
    S_RDATA  = mem[a];
    step();
    S_RVALID = 1'b0;
    S_RDATA  = 8'($urandom);
    check("rd_ackr_start", B_ACK, 1);
    wait_ack("rd_ackr_len");
    for (int i = 0; i < DATA_W; i++) begin
      if (i == rst_bit) begin
        RSTN = 1'b0;
        #1;
        check("rst_async_outputs", {B_ACK, S_WE, S_RE, B_BUS_OUT, S_ADDR, S_WDATA}, 0);
        B_UTIL = 1'b0; S_SEL = 1'b0;
        repeat (3) step();
        RSTN = 1'b1;
        last_wdata = '0;
        step();
        $display("read addr=%03h reset during bit %0d", a, i);
        return;
      end
      bits = {bits[DATA_W-2:0], B_BUS_OUT};
      step();
    end
    check("rd_bits", bits, mem[a]);
    check("rd_out_idle", B_BUS_OUT, 0);
    check("rd_wdata_hold", S_WDATA, last_wdata);
    $display("read addr=%03h data=%02h ready_delay=%0d rlat=%0d", a, bits, k, rl);
    B_UTIL = 1'b0; S_SEL = 1'b0;
    step();
  endtask

  task automatic write_abort(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    send_addr(a);
    B_BUS_IN = 1'b1;
    step();
    wait_ack("ab_acka_len");
    for (int i = DATA_W - 1; i > 4; i--) begin
      B_BUS_IN = d[i];
      step();
    end
    S_SEL = 1'b0;         // drop select in the bit-4 cycle
    B_BUS_IN = d[4];
    step();
    check("ab_ack_low", B_ACK, 0);
    B_UTIL = 1'b0;
    idle_watch("ab_quiet", 20);
    check("ab_wdata_hold", S_WDATA, last_wdata);
    $display("abort write addr=%03h at data bit 4", a);
  endtask

  initial begin
    logic [ADDR_W-1:0] a;
    for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);

    #2 RSTN = 1'b0;
    #1 check("reset_outputs", {B_ACK, S_WE, S_RE, B_BUS_OUT, S_ADDR, S_WDATA}, 0);
    repeat (3) step();
    RSTN = 1'b1;
    step();
    idle_watch("post_reset", 5);

    // Directed frames
    write_frame(12'hA5C, 8'hAD, 0, 1'b0);
    mem[12'h123] = 8'hB5;
    read_frame(12'h123, 0, 2, -1);
    write_frame(12'h7E1, 8'h3C, 5, 1'b0);       // backpressure
    write_abort(12'h456, 8'h99);
    write_frame(12'h456, 8'h5A, 1, 1'b0);       // frame after abort
    mem[12'h3C7] = 8'h96;
    read_frame(12'h3C7, 1, 1, 3);               // reset mid-RDATA
    idle_watch("after_rst", 10);
    read_frame(12'hA5C, 0, 1, -1);

    // Not selected: bus busy with another slave
    B_UTIL = 1'b1; S_SEL = 1'b0;
    idle_watch("not_selected", 40);
    B_UTIL = 1'b0;
    step();

    // act held high after a completed frame
    write_frame(12'h0F0, 8'hE7, 2, 1'b1);
    idle_watch("held_act", 30);
    B_UTIL = 1'b0; S_SEL = 1'b0;
    step();

    // Randomized traffic
    for (int t = 0; t < 14; t++) begin
      if ($urandom_range(0, 1) == 0) begin
        write_frame(12'($urandom), 8'($urandom), $urandom_range(0, 3), 1'b0);
      end else begin
        if (wq.size() > 0 && $urandom_range(0, 1) == 1)
          a = wq[$urandom_range(0, wq.size() - 1)];
        else
          a = 12'($urandom);
        read_frame(a, $urandom_range(0, 3), $urandom_range(1, 3), -1);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
